// File: rtl/padattr_ctrl.sv
// padattr_ctrl: staged per-pad attribute registers with a timed commit to the pad outputs.
// Define PADATTR_CTRL_LOCK_EN to add per-pad sticky locks at 0x80+i (MIO) and 0xC0+j (DIO).
module padattr_ctrl #(
  parameter int unsigned NMioPads     = 16,
  parameter int unsigned NDioPads     = 4,
  parameter int unsigned AttrDw       = 8,
  parameter int unsigned SettleCycles = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       reg_req_i,
  input  logic                       reg_we_i,
  input  logic [7:0]                 reg_addr_i,
  input  logic [31:0]                reg_wdata_i,
  output logic                       reg_rvalid_o,
  output logic [31:0]                reg_rdata_o,
  output logic                       reg_err_o,
  output logic [NMioPads*AttrDw-1:0] mio_attr_o,
  output logic [NDioPads*AttrDw-1:0] dio_attr_o,
  output logic                       busy_o
);

  typedef enum logic [1:0] {IDLE, SETTLE, APPLY} state_e;

  state_e              state_q, state_d;
  logic [7:0]          cnt_q, cnt_d;
  logic                apply;
  logic                commit;

  logic [AttrDw-1:0]   mio_stage_q [NMioPads];
  logic [AttrDw-1:0]   dio_stage_q [NDioPads];
  logic [NMioPads-1:0] mio_locked, mio_we;
  logic [NDioPads-1:0] dio_locked, dio_we;

  logic                rsp_err;
  logic [31:0]         rsp_rdata;

  logic [1:0]          region;
  logic [5:0]          idx;
  logic                is_ctrl;
  logic                unused_wdata;

  assign region       = reg_addr_i[7:6];
  assign idx          = reg_addr_i[5:0];
  assign is_ctrl      = (reg_addr_i == 8'hFF);
  assign unused_wdata = ^reg_wdata_i;

`ifdef PADATTR_CTRL_LOCK_EN
  logic [NMioPads-1:0] mio_lock_q, mio_lock_set;
  logic [NDioPads-1:0] dio_lock_q, dio_lock_set;

  assign mio_locked = mio_lock_q;
  assign dio_locked = dio_lock_q;

  // Locks are sticky: only reset clears them.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mio_lock_q <= '0;
      dio_lock_q <= '0;
    end else begin
      mio_lock_q <= mio_lock_q | mio_lock_set;
      dio_lock_q <= dio_lock_q | dio_lock_set;
    end
  end
`else
  assign mio_locked = '0;
  assign dio_locked = '0;
`endif

  // Register access decode; 0xFF takes priority over the DIO lock window.
  always_comb begin
    rsp_err   = 1'b0;
    rsp_rdata = '0;
    mio_we    = '0;
    dio_we    = '0;
    commit    = 1'b0;
`ifdef PADATTR_CTRL_LOCK_EN
    mio_lock_set = '0;
    dio_lock_set = '0;
`endif
    if (reg_req_i) begin
      if (is_ctrl) begin
        if (!reg_we_i)   rsp_rdata = {30'b0, apply, busy_o};
        else if (busy_o) rsp_err   = 1'b1;
        else             commit    = reg_wdata_i[0];
      end else if (region == 2'd0 && 32'(idx) < NMioPads) begin
        for (int unsigned i = 0; i < NMioPads; i++) begin
          if (32'(idx) == i) begin
            if (!reg_we_i)                   rsp_rdata[AttrDw-1:0] = mio_stage_q[i];
            else if (busy_o || mio_locked[i]) rsp_err = 1'b1;
            else                             mio_we[i] = 1'b1;
          end
        end
      end else if (region == 2'd1 && 32'(idx) < NDioPads) begin
        for (int unsigned j = 0; j < NDioPads; j++) begin
          if (32'(idx) == j) begin
            if (!reg_we_i)                   rsp_rdata[AttrDw-1:0] = dio_stage_q[j];
            else if (busy_o || dio_locked[j]) rsp_err = 1'b1;
            else                             dio_we[j] = 1'b1;
          end
        end
      end
`ifdef PADATTR_CTRL_LOCK_EN
      else if (region == 2'd2 && 32'(idx) < NMioPads) begin
        for (int unsigned i = 0; i < NMioPads; i++) begin
          if (32'(idx) == i) begin
            if (!reg_we_i) rsp_rdata[0]    = mio_lock_q[i];
            else           mio_lock_set[i] = reg_wdata_i[0];
          end
        end
      end else if (region == 2'd3 && 32'(idx) < NDioPads) begin
        for (int unsigned j = 0; j < NDioPads; j++) begin
          if (32'(idx) == j) begin
            if (!reg_we_i) rsp_rdata[0]    = dio_lock_q[j];
            else           dio_lock_set[j] = reg_wdata_i[0];
          end
        end
      end
`endif
      else begin
        rsp_err = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (commit) begin
          state_d = SETTLE;
          cnt_d   = 8'(SettleCycles - 1);
        end
      end
      SETTLE: begin
        if (cnt_q == '0) state_d = APPLY;
        else             cnt_d   = cnt_q - 8'd1;
      end
      APPLY:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy_o = (state_q != IDLE);
    apply  = (state_q == APPLY);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < NMioPads; i++) mio_stage_q[i] <= '0;
      for (int unsigned j = 0; j < NDioPads; j++) dio_stage_q[j] <= '0;
    end else begin
      for (int unsigned i = 0; i < NMioPads; i++)
        if (mio_we[i]) mio_stage_q[i] <= reg_wdata_i[AttrDw-1:0];
      for (int unsigned j = 0; j < NDioPads; j++)
        if (dio_we[j]) dio_stage_q[j] <= reg_wdata_i[AttrDw-1:0];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mio_attr_o <= '0;
      dio_attr_o <= '0;
    end else if (apply) begin
      for (int unsigned i = 0; i < NMioPads; i++)
        mio_attr_o[i*AttrDw +: AttrDw] <= mio_stage_q[i];
      for (int unsigned j = 0; j < NDioPads; j++)
        dio_attr_o[j*AttrDw +: AttrDw] <= dio_stage_q[j];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      reg_rvalid_o <= 1'b0;
      reg_err_o    <= 1'b0;
      reg_rdata_o  <= '0;
    end else begin
      reg_rvalid_o <= reg_req_i;
      reg_err_o    <= rsp_err;
      reg_rdata_o  <= rsp_rdata;
    end
  end

endmodule

// File: tb/tb_padattr_ctrl.sv
// tb_padattr_ctrl: randomized + directed bench for padattr_ctrl with a queue-based scoreboard.
// Follows PADATTR_CTRL_LOCK_EN so the reference model matches the build.
module tb_padattr_ctrl;
  localparam int unsigned NMIO   = 16;
  localparam int unsigned NDIO   = 4;
  localparam int unsigned ADW    = 8;
  localparam int unsigned SETTLE = 4;
  localparam int unsigned MW     = NMIO * ADW;
  localparam int unsigned DW     = NDIO * ADW;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          reg_req_i = 1'b0;
  logic          reg_we_i = 1'b0;
  logic [7:0]    reg_addr_i = '0;
  logic [31:0]   reg_wdata_i = '0;
  logic          reg_rvalid_o;
  logic [31:0]   reg_rdata_o;
  logic          reg_err_o;
  logic [MW-1:0] mio_attr_o;
  logic [DW-1:0] dio_attr_o;
  logic          busy_o;

  padattr_ctrl #(
    .NMioPads(NMIO), .NDioPads(NDIO), .AttrDw(ADW), .SettleCycles(SETTLE)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .reg_req_i(reg_req_i), .reg_we_i(reg_we_i),
    .reg_addr_i(reg_addr_i), .reg_wdata_i(reg_wdata_i), .reg_rvalid_o(reg_rvalid_o),
    .reg_rdata_o(reg_rdata_o), .reg_err_o(reg_err_o), .mio_attr_o(mio_attr_o),
    .dio_attr_o(dio_attr_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    time           t;
    logic          valid;
    logic          we;
    logic          err;
    logic [31:0]   rdata;
    logic          busy;
    logic [MW-1:0] mio;
    logic [DW-1:0] dio;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model: staging/applied pad values, locks, and the cycle a commit was accepted.
  logic [ADW-1:0] m_mio_stage [NMIO];
  logic [ADW-1:0] m_dio_stage [NDIO];
  logic [ADW-1:0] m_mio_app   [NMIO];
  logic [ADW-1:0] m_dio_app   [NDIO];
  bit             m_mio_lock  [NMIO];
  bit             m_dio_lock  [NDIO];
  bit             commit_active = 0;
  int             commit_t = 0;
  int             cyc = 0;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h (t=%0t)", name, got, want, $time);
    end
  endtask

  function automatic bit busy_at(input int c);
    return commit_active && (c > commit_t) && (c <= commit_t + int'(SETTLE) + 1);
  endfunction

  task automatic model_clear();
    for (int i = 0; i < int'(NMIO); i++) begin
      m_mio_stage[i] = '0; m_mio_app[i] = '0; m_mio_lock[i] = 0;
    end
    for (int j = 0; j < int'(NDIO); j++) begin
      m_dio_stage[j] = '0; m_dio_app[j] = '0; m_dio_lock[j] = 0;
    end
    commit_active = 0;
  endtask

  // One bus cycle: drive at negedge, predict the response and post-edge outputs.
  task automatic cycle(input bit req, input bit we, input logic [7:0] addr, input logic [31:0] wdata);
    exp_t e;
    bit   busy, apply;
    int   a;
    @(negedge clk_i);
    reg_req_i = req; reg_we_i = we; reg_addr_i = addr; reg_wdata_i = wdata;
    busy  = busy_at(cyc);
    apply = busy && (cyc == commit_t + int'(SETTLE) + 1);
    e.t = $time; e.valid = req; e.we = we; e.err = 0; e.rdata = '0;
    a = int'(addr);
    if (req) begin
      if (a == 255) begin
        if (!we)           e.rdata = {30'b0, apply, busy};
        else if (busy)     e.err = 1;
        else if (wdata[0]) begin commit_active = 1; commit_t = cyc; end
      end else if (a < 64 && a < int'(NMIO)) begin
        if (!we)                        e.rdata = 32'(m_mio_stage[a]);
        else if (busy || m_mio_lock[a]) e.err = 1;
        else                            m_mio_stage[a] = wdata[ADW-1:0];
      end else if (a >= 64 && a < 128 && a - 64 < int'(NDIO)) begin
        if (!we)                             e.rdata = 32'(m_dio_stage[a-64]);
        else if (busy || m_dio_lock[a-64])   e.err = 1;
        else                                 m_dio_stage[a-64] = wdata[ADW-1:0];
      end
`ifdef PADATTR_CTRL_LOCK_EN
      else if (a >= 128 && a < 192 && a - 128 < int'(NMIO)) begin
        if (!we)          e.rdata = {31'b0, m_mio_lock[a-128]};
        else if (wdata[0]) m_mio_lock[a-128] = 1;
      end else if (a >= 192 && a - 192 < int'(NDIO)) begin
        if (!we)          e.rdata = {31'b0, m_dio_lock[a-192]};
        else if (wdata[0]) m_dio_lock[a-192] = 1;
      end
`endif
      else begin
        e.err = 1;
      end
    end
    if (apply) begin
      for (int i = 0; i < int'(NMIO); i++) m_mio_app[i] = m_mio_stage[i];
      for (int j = 0; j < int'(NDIO); j++) m_dio_app[j] = m_dio_stage[j];
    end
    e.busy = busy_at(cyc + 1);
    for (int i = 0; i < int'(NMIO); i++) e.mio[i*ADW +: ADW] = m_mio_app[i];
    for (int j = 0; j < int'(NDIO); j++) e.dio[j*ADW +: ADW] = m_dio_app[j];
    sb.push_back(e);
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle(0, 0, 8'h00, 32'h0);
  endtask

  task automatic reset_check(input string tag);
    check({tag, "_busy"}, 128'(busy_o), 128'(0));
    check({tag, "_mio"}, 128'(mio_attr_o), 128'(0));
    check({tag, "_dio"}, 128'(dio_attr_o), 128'(0));
    check({tag, "_rvalid"}, 128'(reg_rvalid_o), 128'(0));
  endtask

  // Reset asserted mid-cycle, away from any clock edge.
  task automatic reset_mid();
    @(posedge clk_i);
    #2 rst_ni = 1'b0;
    #1 reset_check("rst_mid");
    sb.delete();
    model_clear();
    reg_req_i = 0; reg_we_i = 0;
    repeat (2) @(posedge clk_i);
    #3 rst_ni = 1'b1;
  endtask

  // Monitor: pops only expectations pushed strictly before the current edge.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk_i);
      if (rst_ni) begin
        if (sb.size() > 0 && sb[0].t < $time) begin
          e = sb.pop_front();
          check("rvalid", 128'(reg_rvalid_o), 128'(e.valid));
          if (e.valid) begin
            check("err", 128'(reg_err_o), 128'(e.err));
            if (!e.we || e.err) check("rdata", 128'(reg_rdata_o), 128'(e.rdata));
          end
          check("busy", 128'(busy_o), 128'(e.busy));
          check("mio_attr", 128'(mio_attr_o), 128'(e.mio));
          check("dio_attr", 128'(dio_attr_o), 128'(e.dio));
        end else if (sb.size() == 0) begin
          check("rvalid_idle", 128'(reg_rvalid_o), 128'(0));
        end
      end
    end
  end

  initial begin : stimulus
    logic [7:0]  addr;
    logic [31:0] wd;
    int          kind;
    model_clear();
    repeat (2) @(posedge clk_i);
    #1 reset_check("rst_init");
    #2 rst_ni = 1'b1;

    // Commit timing and busy-window rejection
    cycle(1, 1, 8'h00, 32'hA5);
    cycle(1, 1, 8'hFF, 32'h1);
    cycle(1, 0, 8'hFF, 32'h0);
    cycle(1, 1, 8'h40, 32'h5A);
    cycle(1, 1, 8'hFF, 32'h1);
    idle(2);
    cycle(1, 0, 8'hFF, 32'h0);
    idle(2);
    cycle(1, 0, 8'h40, 32'h0);

    // Unmapped index, truncated write, no-op commit
    cycle(1, 0, 8'h3F, 32'h0);
    cycle(1, 1, 8'h01, 32'h1FF);
    cycle(1, 0, 8'h01, 32'h0);
    cycle(1, 1, 8'hFF, 32'h0);
    cycle(1, 0, 8'hFF, 32'h0);
    cycle(1, 1, 8'h43, 32'hC3);
    cycle(1, 0, 8'h44, 32'h0);

    // Lock behaviour (unmapped when locks are compiled out)
    cycle(1, 1, 8'h80, 32'h1);
    cycle(1, 1, 8'h00, 32'h33);
    cycle(1, 0, 8'h00, 32'h0);
    cycle(1, 0, 8'h80, 32'h0);
    cycle(1, 1, 8'h81, 32'h0);
    cycle(1, 0, 8'h81, 32'h0);
    cycle(1, 0, 8'hC3, 32'h0);

    // Reset during SETTLE, then a fresh commit
    cycle(1, 1, 8'hFF, 32'h1);
    cycle(0, 0, 8'h00, 32'h0);
    reset_mid();
    cycle(1, 1, 8'h00, 32'h11);
    cycle(1, 1, 8'h42, 32'h77);
    cycle(1, 1, 8'hFF, 32'h1);
    idle(7);
    cycle(1, 0, 8'h00, 32'h0);

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      kind = int'($urandom_range(0, 9));
      wd   = $urandom;
      case (kind)
        0, 1, 2: addr = 8'($urandom_range(0, NMIO - 1));
        3:       addr = 8'(64 + $urandom_range(0, NDIO - 1));
        4:       begin addr = 8'hFF; wd[0] = ($urandom_range(0, 3) != 0); end
        5:       addr = ($urandom_range(0, 1) != 0) ? 8'(128 + $urandom_range(0, NMIO - 1))
                                                     : 8'(192 + $urandom_range(0, NDIO - 1));
        6:       addr = 8'($urandom_range(0, 255));
        default: addr = 8'($urandom_range(0, NMIO - 1));
      endcase
      if (kind >= 8) cycle(0, 0, addr, wd);
      else           cycle(1, ($urandom_range(0, 1) != 0), addr, wd);
    end
    idle(8);

    for (int k = 0; k < 10 && sb.size() > 0; k++) @(negedge clk_i);
    @(posedge clk_i);
    if (sb.size() > 0) check("sb_drain", 128'(sb.size()), 128'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/padattr_ctrl.md
PADATTR_CTRL -- requirements
Module: padattr_ctrl

Interface
REQ-001 SHALL have parameter NMioPads, default 16, number of muxed IO pads (1..64).
REQ-002 SHALL have parameter NDioPads, default 4, number of dedicated IO pads (1..64).
REQ-003 SHALL have parameter AttrDw, default 8, attribute bits per pad (1..32).
REQ-004 SHALL have parameter SettleCycles, default 4, commit settle delay in cycles (1..255).
REQ-005 SHALL have port clk_i, input, 1, the single clock; all state on its rising edge.
REQ-006 SHALL have port rst_ni, input, 1, reset; asynchronous, active-low.
REQ-007 SHALL have port reg_req_i, input, 1, register access request.
REQ-008 SHALL have port reg_we_i, input, 1, 1=write, 0=read.
REQ-009 SHALL have port reg_addr_i, input, 8, word index.
REQ-010 SHALL have port reg_wdata_i, input, 32, write data.
REQ-011 SHALL have port reg_rvalid_o, output, 1, response valid.
REQ-012 SHALL have port reg_rdata_o, output, 32, read data.
REQ-013 SHALL have port reg_err_o, output, 1, access error, valid with reg_rvalid_o.
REQ-014 SHALL have port mio_attr_o, output, NMioPads*AttrDw, applied MIO attributes, pad i at [i*AttrDw +: AttrDw].
REQ-015 SHALL have port dio_attr_o, output, NDioPads*AttrDw, applied DIO attributes, same packing.
REQ-016 SHALL have port busy_o, output, 1, commit in progress.

Function
REQ-017 SHALL decode: 0x00+i MIO stage i; 0x40+j DIO stage j; 0x80+i MIO lock i; 0xC0+j DIO lock j; 0xFF CTRL/STATUS; any other index is unmapped.
REQ-018 SHALL always accept a request; reg_rvalid_o pulses exactly one cycle after each cycle with reg_req_i=1, with rdata/err.
REQ-019 SHALL on stage write store reg_wdata_i[AttrDw-1:0] into staging; outputs unchanged until commit.
REQ-020 SHALL on stage read return staging value zero-extended to 32 bits.
REQ-021 SHALL on unmapped access set err=1, rdata=0, no state change.
REQ-022 SHALL implement FSM IDLE -> SETTLE -> APPLY -> IDLE.
REQ-023 SHALL in IDLE, on write to 0xFF with wdata[0]=1, enter SETTLE and load counter with SettleCycles-1.
REQ-024 SHALL in SETTLE decrement counter each cycle; at counter 0 enter APPLY.
REQ-025 SHALL in APPLY copy all staging registers to mio_attr_o/dio_attr_o in that cycle's edge, then return to IDLE.
REQ-026 SHALL result in outputs updating SettleCycles+1 cycles after the commit-write cycle.
REQ-027 SHALL assert busy_o in SETTLE and APPLY only.
REQ-028 SHALL while busy reject stage writes and commit writes with err=1, no state change; reads remain legal.
REQ-029 SHALL read 0xFF as {30'b0, state==APPLY, busy_o}.
REQ-030 SHALL not allow a commit write with wdata[0]=0 to change state (err=0).

Reset
REQ-031 SHALL on rst_ni low immediately clear staging, locks, outputs, counter, reg_rvalid_o, reg_err_o, reg_rdata_o and return FSM to IDLE, including mid-commit.
REQ-032 SHALL drive mio_attr_o=0, dio_attr_o=0, busy_o=0 throughout reset.

Configuration
REQ-033 SHALL with PADATTR_CTRL_LOCK_EN defined implement per-pad sticky locks: lock write with wdata[0]=1 sets lock, wdata[0]=0 no effect, cleared only by reset; lock read returns lock bit.
REQ-034 SHALL with PADATTR_CTRL_LOCK_EN defined reject stage writes to a locked pad with err=1, leaving staging unchanged.
REQ-035 SHALL without PADATTR_CTRL_LOCK_EN treat 0x80-0xFE as unmapped and implement no lock storage.

Verification
REQ-036 SHALL verify: write 0x00=0xA5, commit at cycle T (SettleCycles=4) -> mio_attr_o[7:0]=0x00 through T+4, 0xA5 after edge T+5; busy_o high T+1..T+5.
REQ-037 SHALL verify: write 0x40 during busy -> err=1, staging DIO0 unchanged; read 0xFF during SETTLE -> 0x1.
REQ-038 SHALL verify: read 0x3F with NMioPads=16 -> err=1, rdata=0; read 0x01 after writing 0x1FF -> rdata=0xFF.
REQ-039 SHALL verify (LOCK_EN): write 0x80=1, then write 0x00=0x33 -> err=1, read 0x00 returns prior value; read 0x80 -> 1.
REQ-040 SHALL verify: assert rst_ni low during SETTLE -> busy_o=0, outputs 0 immediately; after release a fresh commit completes normally.
